matmul_job_sched: RTL and testbench

Job scheduler in front of the systolic memory controller. It queues matrix-multiply jobs (AS/SA/SB/BS), launches each one with a one-cycle `calc_init` and a mode, and counts result blocks by watching the controller's state code. It paces the controller's HASH wait with a single-cycle `hash_ready` pulse per HASH block, and at job end returns the controller to IDLE and reports completion. It sits between the top-level sequencer/HASH engine and the memory controller.

---
 rtl/matmul_job_sched_if.sv | 35 +++
 rtl/matmul_job_sched.sv | 191 +++++++++++++++++++
 tb/tb_matmul_job_sched.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/matmul_job_sched_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// matmul_job_sched_if: job queue, controller and HASH-pacing signals. Rev 1.0
// ----------------------------------------------------------------------------
interface matmul_job_sched_if #(
  parameter int NBLK_W = 10
);
  logic              job_valid;
  logic              job_ready;
  logic [2:0]        job_mode;
  logic [NBLK_W-1:0] job_nblk;
  logic [2:0]        mem_mode;
  logic              calc_init;
  logic [3:0]        ctrl_state;
  logic              hash_blk_valid;
  logic              hash_blk_take;
  logic              hash_ready;
  logic              busy;
  logic              done;
  logic [2:0]        done_mode;
  logic              err;

  modport master (
    output job_valid, job_mode, job_nblk, ctrl_state, hash_blk_valid,
    input  job_ready, mem_mode, calc_init, hash_blk_take, hash_ready,
           busy, done, done_mode, err
  );

  modport slave (
    input  job_valid, job_mode, job_nblk, ctrl_state, hash_blk_valid,
    output job_ready, mem_mode, calc_init, hash_blk_take, hash_ready,
           busy, done, done_mode, err
  );
endinterface
`default_nettype wire

// File: rtl/matmul_job_sched.sv
`default_nettype none
// ----------------------------------------------------------------------------
// matmul_job_sched: job FIFO + launch/pace/report FSM for the systolic memory
// controller; define MATMUL_SCHED_WDOG_EN for the RUN watchdog. Rev 1.0
// ----------------------------------------------------------------------------
module matmul_job_sched #(
  parameter int         DEPTH       = 4,
  parameter int         NBLK_W      = 10,
  parameter logic [3:0] WAIT_CODE   = 4'd3,
  parameter int         WDOG_CYCLES = 65536
) (
  input  logic              clk,
  input  logic              rst,
  matmul_job_sched_if.slave bus
);
  localparam int                AW       = $clog2(DEPTH);
  localparam int                CW       = AW + 1;
  localparam logic [CW-1:0]     FULL_CNT = CW'(DEPTH);
  localparam logic [NBLK_W-1:0] ONE_BLK  = NBLK_W'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_RUN    = 3'd2,
    S_STOP   = 3'd3,
    S_REPORT = 3'd4
  } state_t;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || WDOG_CYCLES < 1) begin : g_param_check
    $error("matmul_job_sched: DEPTH must be a power of two >= 2, WDOG_CYCLES >= 1");
  end

  logic [NBLK_W+2:0] fifo_mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     fifo_cnt;
  logic              fifo_empty, push, pop;
  logic [2:0]        head_mode;
  logic [NBLK_W-1:0] head_nblk;
  logic              head_legal;

  state_t            state;
  logic [2:0]        job_mode_q;
  logic [NBLK_W-1:0] job_nblk_q;
  logic [NBLK_W-1:0] blk_cnt;
  logic [NBLK_W-1:0] blk_next;
  logic [3:0]        prev_ctrl;
  logic              grant_pend;
  logic              block_edge;
  logic              hash_go;
  logic [2:0]        mem_mode_q;
  logic              calc_init_q, busy_q, done_q, err_q;
  logic [2:0]        done_mode_q;

  assign fifo_empty    = (fifo_cnt == '0);
  assign bus.job_ready = (fifo_cnt != FULL_CNT);
  assign push          = bus.job_valid && bus.job_ready;
  assign pop           = (state == S_IDLE) && !fifo_empty;
  assign {head_mode, head_nblk} = fifo_mem[rd_ptr];
  assign head_legal    = (head_mode != 3'd0) && (head_mode <= 3'd4);

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {bus.job_mode, bus.job_nblk};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  assign block_edge = (bus.ctrl_state == WAIT_CODE) && (prev_ctrl != WAIT_CODE);
  assign blk_next   = blk_cnt + ONE_BLK;
  // Never release on an edge cycle, so the final edge cannot leak a hash_ready.
  assign hash_go    = (state == S_RUN) && grant_pend && bus.hash_blk_valid &&
                      (bus.ctrl_state == WAIT_CODE) && !block_edge;

`ifdef MATMUL_SCHED_WDOG_EN
  localparam int             WDW       = $clog2(WDOG_CYCLES + 1);
  localparam logic [WDW-1:0] WDOG_LAST = WDW'(WDOG_CYCLES - 1);
  logic [WDW-1:0] wdog_cnt;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      job_mode_q  <= '0;
      job_nblk_q  <= '0;
      blk_cnt     <= '0;
      prev_ctrl   <= '0;
      grant_pend  <= 1'b0;
      mem_mode_q  <= '0;
      calc_init_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      done_mode_q <= '0;
      err_q       <= 1'b0;
`ifdef MATMUL_SCHED_WDOG_EN
      wdog_cnt    <= '0;
`endif
    end else begin
      prev_ctrl   <= bus.ctrl_state;
      calc_init_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!fifo_empty) begin
            if (head_legal) begin
              state       <= S_LAUNCH;
              job_mode_q  <= head_mode;
              job_nblk_q  <= (head_nblk == '0) ? ONE_BLK : head_nblk;
              blk_cnt     <= '0;
              grant_pend  <= 1'b0;
              calc_init_q <= 1'b1;
              mem_mode_q  <= head_mode;
              busy_q      <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_LAUNCH: begin
          state <= S_RUN;
`ifdef MATMUL_SCHED_WDOG_EN
          wdog_cnt <= '0;
`endif
        end
        S_RUN: begin
          if (hash_go) grant_pend <= 1'b0;
          if (block_edge) begin
            blk_cnt <= blk_next;
            if (blk_next == job_nblk_q) begin
              state       <= S_STOP;
              calc_init_q <= 1'b1;
              mem_mode_q  <= '0;
              grant_pend  <= 1'b0;
            end else begin
              grant_pend <= 1'b1;
            end
          end
`ifdef MATMUL_SCHED_WDOG_EN
          if (block_edge) begin
            wdog_cnt <= '0;
          end else if (wdog_cnt == WDOG_LAST) begin
            err_q       <= 1'b1;
            state       <= S_STOP;
            calc_init_q <= 1'b1;
            mem_mode_q  <= '0;
            grant_pend  <= 1'b0;
          end else begin
            wdog_cnt <= wdog_cnt + WDW'(1);
          end
`endif
        end
        S_STOP: begin
          state       <= S_REPORT;
          done_q      <= 1'b1;
          done_mode_q <= job_mode_q;
        end
        S_REPORT: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_mode      = mem_mode_q;
  assign bus.calc_init     = calc_init_q;
  assign bus.hash_ready    = hash_go;
  assign bus.hash_blk_take = hash_go;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.done_mode     = done_mode_q;
  assign bus.err           = err_q;
endmodule
`default_nettype wire

// File: tb/tb_matmul_job_sched.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_matmul_job_sched: directed self-checking bench for matmul_job_sched. Rev 1.0
// ----------------------------------------------------------------------------
module tb_matmul_job_sched;
  localparam int         NBLK_W = 10;
  localparam logic [3:0] WAIT_C = 4'd3;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  matmul_job_sched_if #(.NBLK_W(NBLK_W)) bus ();

  matmul_job_sched #(
    .DEPTH(4), .NBLK_W(NBLK_W), .WAIT_CODE(WAIT_C), .WDOG_CYCLES(100)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled mid-cycle, away from the active edge.
  int         hr_cnt = 0, done_cnt = 0, err_cnt = 0, stop_cnt = 0, launch_n = 0;
  logic [2:0] launch_log [64];
  always @(negedge clk) begin
    if (bus.hash_ready) hr_cnt++;
    if (bus.done) done_cnt++;
    if (bus.err) err_cnt++;
    if (bus.calc_init) begin
      if (bus.mem_mode == 3'd0) stop_cnt++;
      else begin
        launch_log[launch_n[5:0]] = bus.mem_mode;
        launch_n++;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_job(input logic [2:0] mode, input logic [NBLK_W-1:0] nblk);
    bus.job_valid = 1'b1;
    bus.job_mode  = mode;
    bus.job_nblk  = nblk;
    tick();
    bus.job_valid = 1'b0;
  endtask

  task automatic wait_launch(input int k);
    int t = 0;
    while (launch_n <= k && t < 200) begin
      tick();
      t++;
    end
    check("launch_seen", 32'(launch_n > k), 32'd1);
  endtask

  task automatic wait_done();
    int t = 0;
    while (!bus.done && t < 200) begin
      tick();
      t++;
    end
    check("done_seen", 32'(bus.done), 32'd1);
  endtask

  task automatic do_block();
    bus.ctrl_state = WAIT_C;
    repeat (3) tick();
    bus.ctrl_state = 4'd1;
    tick();
  endtask

  task automatic last_block();
    bus.ctrl_state = WAIT_C;
    tick();
    bus.ctrl_state = 4'd1;
  endtask

  int hr0, d0, e0, l0, s0;
  logic [2:0] exp_modes [5];

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.job_valid = 1'b0;
    bus.job_mode = '0;
    bus.job_nblk = '0;
    bus.ctrl_state = 4'd1;
    bus.hash_blk_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_job_ready", 32'(bus.job_ready), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_calc_init", 32'(bus.calc_init), 32'd0);
    check("rst_mem_mode", 32'(bus.mem_mode), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_done_mode", 32'(bus.done_mode), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_hash_ready", 32'(bus.hash_ready), 32'd0);
    rst = 1'b0;
    tick();

    // AS job with 3 blocks: two releases, one stop strobe, one done.
    bus.hash_blk_valid = 1'b1;
    hr0 = hr_cnt; s0 = stop_cnt; d0 = done_cnt;
    push_job(3'd1, 10'd3);
    check("t1_init_not_yet", 32'(bus.calc_init), 32'd0);
    tick();
    check("t1_launch_init", 32'(bus.calc_init), 32'd1);
    check("t1_launch_mode", 32'(bus.mem_mode), 32'd1);
    check("t1_busy", 32'(bus.busy), 32'd1);
    tick();
    check("t1_init_one_cycle", 32'(bus.calc_init), 32'd0);
    check("t1_mode_hold", 32'(bus.mem_mode), 32'd1);
    do_block();
    do_block();
    bus.ctrl_state = WAIT_C;
    tick();
    check("t1_stop_init", 32'(bus.calc_init), 32'd1);
    check("t1_stop_mode", 32'(bus.mem_mode), 32'd0);
    check("t1_final_no_hr", 32'(bus.hash_ready), 32'd0);
    tick();
    check("t1_done", 32'(bus.done), 32'd1);
    check("t1_done_mode", 32'(bus.done_mode), 32'd1);
    bus.ctrl_state = 4'd1;
    tick();
    check("t1_done_pulse", 32'(bus.done), 32'd0);
    check("t1_idle", 32'(bus.busy), 32'd0);
    check("t1_hr_count", 32'(hr_cnt - hr0), 32'd2);
    check("t1_stop_count", 32'(stop_cnt - s0), 32'd1);
    check("t1_done_count", 32'(done_cnt - d0), 32'd1);

    // Five back-to-back pushes: one launches, four fill the FIFO.
    exp_modes[0] = 3'd1; exp_modes[1] = 3'd2; exp_modes[2] = 3'd3;
    exp_modes[3] = 3'd4; exp_modes[4] = 3'd1;
    l0 = launch_n;
    for (int i = 0; i < 5; i++) begin
      check("t2_ready_before_push", 32'(bus.job_ready), 32'd1);
      bus.job_valid = 1'b1;
      bus.job_mode  = exp_modes[i];
      bus.job_nblk  = 10'd1;
      tick();
    end
    bus.job_valid = 1'b0;
    check("t2_full_ready", 32'(bus.job_ready), 32'd0);
    for (int k = 0; k < 5; k++) begin
      wait_launch(l0 + k);
      check("t2_launch_order", 32'(launch_log[(l0 + k) % 64]), 32'(exp_modes[k]));
      last_block();
      wait_done();
      check("t2_done_mode", 32'(bus.done_mode), 32'(exp_modes[k]));
      tick();
    end

    // Illegal mode is dropped with err; SA with nblk=0 runs one block.
    e0 = err_cnt; l0 = launch_n; hr0 = hr_cnt;
    push_job(3'd6, 10'd5);
    push_job(3'd2, 10'd0);
    wait_launch(l0);
    check("t3_launch_mode", 32'(launch_log[l0 % 64]), 32'd2);
    check("t3_err_count", 32'(err_cnt - e0), 32'd1);
    last_block();
    wait_done();
    check("t3_done_mode", 32'(bus.done_mode), 32'd2);
    tick();
    check("t3_no_hr", 32'(hr_cnt - hr0), 32'd0);
    check("t3_one_launch", 32'(launch_n - l0), 32'd1);

    // Long HASH wait without a buffered block, then release in the same cycle.
    bus.hash_blk_valid = 1'b0;
    l0 = launch_n; hr0 = hr_cnt;
    push_job(3'd1, 10'd2);
    wait_launch(l0);
    bus.ctrl_state = WAIT_C;
    repeat (50) tick();
    check("t4_no_hr_50", 32'(hr_cnt - hr0), 32'd0);
    bus.hash_blk_valid = 1'b1;
    #1;
    check("t4_hr_same_cycle", 32'(bus.hash_ready), 32'd1);
    check("t4_take_same_cycle", 32'(bus.hash_blk_take), 32'd1);
    tick();
    check("t4_hr_cleared", 32'(bus.hash_ready), 32'd0);
    check("t4_take_cleared", 32'(bus.hash_blk_take), 32'd0);
    check("t4_hr_count", 32'(hr_cnt - hr0), 32'd1);
    bus.ctrl_state = 4'd1;
    bus.hash_blk_valid = 1'b0;
    tick();
    last_block();
    wait_done();
    tick();

    // Reset during RUN with two jobs queued.
    bus.hash_blk_valid = 1'b1;
    d0 = done_cnt; l0 = launch_n;
    push_job(3'd1, 10'd4);
    push_job(3'd2, 10'd1);
    push_job(3'd3, 10'd1);
    wait_launch(l0);
    do_block();
    bus.ctrl_state = WAIT_C;
    tick();
    check("t5_pre_rst_hr", 32'(bus.hash_ready), 32'd1);
    rst = 1'b1;
    #1;
    check("t5_rst_busy", 32'(bus.busy), 32'd0);
    check("t5_rst_hr", 32'(bus.hash_ready), 32'd0);
    check("t5_rst_take", 32'(bus.hash_blk_take), 32'd0);
    check("t5_rst_mem_mode", 32'(bus.mem_mode), 32'd0);
    check("t5_rst_calc_init", 32'(bus.calc_init), 32'd0);
    check("t5_rst_done_mode", 32'(bus.done_mode), 32'd0);
    check("t5_rst_job_ready", 32'(bus.job_ready), 32'd1);
    bus.ctrl_state = 4'd1;
    bus.hash_blk_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (20) tick();
    check("t5_no_done", 32'(done_cnt - d0), 32'd0);
    check("t5_queue_dropped", 32'(launch_n - l0), 32'd1);
    check("t5_idle", 32'(bus.busy), 32'd0);

`ifdef MATMUL_SCHED_WDOG_EN
    // Watchdog expiry with no block edge.
    l0 = launch_n;
    push_job(3'd1, 10'd2);
    wait_launch(l0);
    repeat (99) tick();
    check("t6_no_err_early", 32'(bus.err), 32'd0);
    tick();
    check("t6_err", 32'(bus.err), 32'd1);
    check("t6_stop_init", 32'(bus.calc_init), 32'd1);
    check("t6_stop_mode", 32'(bus.mem_mode), 32'd0);
    tick();
    check("t6_done", 32'(bus.done), 32'd1);
    check("t6_err_pulse", 32'(bus.err), 32'd0);
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
